branch_resolve_unit: RTL and testbench

//  Two-stage pipelined branch/jump resolver for the MIPS core. Sits after register read.

---
 rtl/bru_pkg.sv | 56 +++++
 rtl/bru_cmp.sv | 17 +
 rtl/branch_resolve_unit.sv | 126 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: op encoding, pipeline stage payloads, direction rule.
// Optional feature macro used by the top: BRU_PERF_CNT_EN.
package bru_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BLEZ = 3'd2,
        OP_BGTZ = 3'd3,
        OP_BLTZ = 3'd4,
        OP_BGEZ = 3'd5,
        OP_J    = 3'd6,
        OP_JR   = 3'd7
    } op_t;

    // S1 payload: compare flags and pc+4 are already folded in at capture.
    typedef struct packed {
        op_t             op;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] rs;
        logic [25:0]     imm;
        logic            eq;
        logic            ltz;
        logic            eqz;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } s1_t;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
        logic            redirect;
        logic [XLEN-1:0] redirect_pc;
    } s2_t;

    function automatic logic resolve_taken(input op_t op, input logic eq,
                                           input logic ltz, input logic eqz);
        logic t;
        t = 1'b0;
        case (op)
            OP_BEQ:  t = eq;
            OP_BNE:  t = !eq;
            OP_BLEZ: t = ltz | eqz;
            OP_BGTZ: t = !ltz & !eqz;
            OP_BLTZ: t = ltz;
            OP_BGEZ: t = !ltz;
            OP_J:    t = 1'b1;
            OP_JR:   t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/bru_cmp.sv
// Operand comparator for the resolve unit's capture stage: equality, sign and zero of rs.
// Signed sense matches slt: rs[31] alone decides "less than zero".
module bru_cmp
    import bru_pkg::*;
(
    input  logic [XLEN-1:0] i_rs,
    input  logic [XLEN-1:0] i_rt,
    output logic            o_eq,
    output logic            o_ltz,
    output logic            o_eqz
);

    assign o_eq  = (i_rs == i_rt);
    assign o_ltz = i_rs[XLEN-1];
    assign o_eqz = (i_rs == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch/jump resolver: S1 captures and compares, S2 resolves and flags fetch redirects.
// Define BRU_PERF_CNT_EN to add the perf_branches / perf_mispred counter outputs.
module branch_resolve_unit #(
    parameter int unsigned     XLEN   = 32,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs,
    input  logic [XLEN-1:0] in_rt,
    input  logic [25:0]     in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_redirect_pc
`ifdef BRU_PERF_CNT_EN
   ,output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispred
`endif
);
    import bru_pkg::*;

    logic      r_s1_valid;
    s1_t       r_s1;
    logic      w_eq;
    logic      w_ltz;
    logic      w_eqz;
    logic      w_s2_adv;
    logic      w_s1_adv;
    logic [XLEN-1:0] w_br_target;
    s2_t       w_s2_next;

    bru_cmp u_cmp (
        .i_rs  (in_rs),
        .i_rt  (in_rt),
        .o_eq  (w_eq),
        .o_ltz (w_ltz),
        .o_eqz (w_eqz)
    );

    assign w_s2_adv = !out_valid | out_ready;
    assign w_s1_adv = !r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1.op          <= op_t'(in_op);
                r_s1.pc4         <= in_pc + XLEN'(4);
                r_s1.rs          <= in_rs;
                r_s1.imm         <= in_imm;
                r_s1.eq          <= w_eq;
                r_s1.ltz         <= w_ltz;
                r_s1.eqz         <= w_eqz;
                r_s1.pred_taken  <= in_pred_taken;
                r_s1.pred_target <= in_pred_target;
            end
        end
    end

    assign w_br_target = r_s1.pc4 + {{14{r_s1.imm[15]}}, r_s1.imm[15:0], 2'b00};

    always_comb begin
        w_s2_next = '0;
        w_s2_next.taken = resolve_taken(r_s1.op, r_s1.eq, r_s1.ltz, r_s1.eqz);
        case (r_s1.op)
            OP_J:    w_s2_next.target = {r_s1.pc4[XLEN-1:XLEN-4], r_s1.imm, 2'b00};
            OP_JR:   w_s2_next.target = r_s1.rs;
            default: w_s2_next.target = w_br_target;
        endcase
        w_s2_next.redirect = (w_s2_next.taken != r_s1.pred_taken) |
                             (w_s2_next.taken & (r_s1.pred_target != w_s2_next.target));
        // Not-taken resumes after the delay slot, which fetch already has.
        w_s2_next.redirect_pc = w_s2_next.taken ? w_s2_next.target : (r_s1.pc4 + XLEN'(4));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_taken       <= 1'b0;
            out_target      <= '0;
            out_redirect    <= 1'b0;
            out_redirect_pc <= RST_PC;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_taken       <= w_s2_next.taken;
                out_target      <= w_s2_next.target;
                out_redirect    <= w_s2_next.redirect;
                out_redirect_pc <= w_s2_next.redirect_pc;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else if (out_valid && out_ready) begin
            perf_branches <= perf_branches + 32'd1;
            if (out_redirect) begin
                perf_mispred <= perf_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver queues expected results, monitor checks outputs.
module tb_branch_resolve_unit;

    localparam logic [31:0] RST_PC_T = 32'hBFC0_0000;

    localparam logic [2:0] BEQ = 3'd0, BNE = 3'd1, BLEZ = 3'd2, BGTZ = 3'd3,
                           BLTZ = 3'd4, BGEZ = 3'd5, JJ = 3'd6, JR = 3'd7;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        redirect;
        logic [31:0] rpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_pc, in_rs, in_rt, in_pred_target;
    logic [25:0] in_imm;
    logic        in_pred_taken;
    logic        out_valid, out_ready, out_taken, out_redirect;
    logic [31:0] out_target, out_redirect_pc;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispred;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   m_branches = 0;
    int   m_mispred = 0;

    branch_resolve_unit #(.XLEN(32), .RST_PC(RST_PC_T)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_pc           (in_pc),
        .in_rs           (in_rs),
        .in_rt           (in_rt),
        .in_imm          (in_imm),
        .in_pred_taken   (in_pred_taken),
        .in_pred_target  (in_pred_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_taken       (out_taken),
        .out_target      (out_target),
        .out_redirect    (out_redirect),
        .out_redirect_pc (out_redirect_pc)
`ifdef BRU_PERF_CNT_EN
       ,.perf_branches   (perf_branches),
        .perf_mispred    (perf_mispred)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic t, input logic [31:0] tgt,
                                input logic r, input logic [31:0] rpc);
        exp_t e;
        e.taken = t; e.target = tgt; e.redirect = r; e.rpc = rpc;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [25:0] imm, input logic pt,
                        input logic [31:0] ptgt, input exp_t e, input bit push);
        bit acc;
        int n;
        in_valid = 1'b1; in_op = op; in_pc = pc; in_rs = rs; in_rt = rt;
        in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            #4;
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected accept", n);
        end else if (push) begin
            sb.push_back(e);
        end
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got target %h, expected no output", out_target);
            end else begin
                mon_e = sb.pop_front();
                chk("out_taken", {31'd0, out_taken}, {31'd0, mon_e.taken});
                chk("out_target", out_target, mon_e.target);
                chk("out_redirect", {31'd0, out_redirect}, {31'd0, mon_e.redirect});
                chk("out_redirect_pc", out_redirect_pc, mon_e.rpc);
                m_branches++;
                if (mon_e.redirect) m_mispred++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected end before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_pc = '0; in_rs = '0; in_rt = '0; in_imm = '0;
        in_pred_taken = 1'b0; in_pred_target = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_taken", {31'd0, out_taken}, 32'd0);
        chk("rst_out_redirect", {31'd0, out_redirect}, 32'd0);
        chk("rst_out_target", out_target, 32'd0);
        chk("rst_redirect_pc", out_redirect_pc, RST_PC_T);
        @(posedge clk); #1 rst = 1'b0;

        // Directed single ops, streaming back-to-back
        send(BEQ,  32'h100, 32'd5, 32'd5, 26'h4, 1'b0, 32'h0, mk(1'b1, 32'h114, 1'b1, 32'h114), 1'b1);
        send(BLTZ, 32'h300, 32'h8000_0000, 32'h0, 26'h10, 1'b1, 32'h344, mk(1'b1, 32'h344, 1'b0, 32'h344), 1'b1);
        send(BGTZ, 32'h400, 32'h0, 32'h0, 26'h8, 1'b0, 32'h0, mk(1'b0, 32'h424, 1'b0, 32'h408), 1'b1);
        send(BNE,  32'h200, 32'd1, 32'd2, 26'hFFFF, 1'b0, 32'h0, mk(1'b1, 32'h200, 1'b1, 32'h200), 1'b1);
        send(JR,   32'h500, 32'h0040_0000, 32'h0, 26'h0, 1'b1, 32'h0040_0004, mk(1'b1, 32'h0040_0000, 1'b1, 32'h0040_0000), 1'b1);
        send(JJ,   32'h1000_0000, 32'h0, 32'h0, 26'h40, 1'b1, 32'h1000_0100, mk(1'b1, 32'h1000_0100, 1'b0, 32'h1000_0100), 1'b1);
        send(BGEZ, 32'h600, 32'hFFFF_FFFF, 32'h0, 26'h2, 1'b1, 32'h60C, mk(1'b0, 32'h60C, 1'b1, 32'h608), 1'b1);
        send(BLEZ, 32'h700, 32'h0, 32'h0, 26'h1, 1'b1, 32'h708, mk(1'b1, 32'h708, 1'b0, 32'h708), 1'b1);
        send(BLEZ, 32'h720, 32'h8000_0001, 32'h0, 26'h0, 1'b0, 32'h0, mk(1'b1, 32'h724, 1'b1, 32'h724), 1'b1);
        send(BEQ,  32'h800, 32'd1, 32'd2, 26'h0, 1'b1, 32'h804, mk(1'b0, 32'h804, 1'b1, 32'h808), 1'b1);
        send(BNE,  32'hFFFF_FFF0, 32'd1, 32'd0, 26'h10, 1'b0, 32'h0, mk(1'b1, 32'h34, 1'b1, 32'h34), 1'b1);
        send(BGTZ, 32'h900, 32'd1, 32'd0, 26'h3, 1'b1, 32'h914, mk(1'b1, 32'h910, 1'b1, 32'h910), 1'b1);
        send(BEQ,  32'h100, 32'd7, 32'd7, 26'h3FF_0004, 1'b1, 32'h114, mk(1'b1, 32'h114, 1'b0, 32'h114), 1'b1);
        idle_in();
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: two accepts fill the pipe, then outputs must hold
        out_ready = 1'b0;
        send(BEQ, 32'hA00, 32'd0, 32'd0, 26'h1, 1'b1, 32'hA08, mk(1'b1, 32'hA08, 1'b0, 32'hA08), 1'b1);
        send(BNE, 32'hB00, 32'd3, 32'd3, 26'h2, 1'b0, 32'h0, mk(1'b0, 32'hB0C, 1'b0, 32'hB08), 1'b1);
        fork
            begin
                send(BLTZ, 32'hC00, 32'd5, 32'd0, 26'h4, 1'b1, 32'hC14, mk(1'b0, 32'hC14, 1'b1, 32'hC08), 1'b1);
                send(JJ, 32'h2000_0000, 32'h0, 32'h0, 26'h3FF_FFFF, 1'b1, 32'h2FFF_FFFC,
                     mk(1'b1, 32'h2FFF_FFFC, 1'b0, 32'h2FFF_FFFC), 1'b1);
                idle_in();
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_hold_target", out_target, 32'hA08);
                    chk("stall_hold_rpc", out_redirect_pc, 32'hA08);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;

        // Flush with both stages occupied and a new request presented
        out_ready = 1'b0;
        send(BEQ, 32'hF00, 32'd1, 32'd1, 26'h1, 1'b0, 32'h0, mk(1'b0, 32'h0, 1'b0, 32'h0), 1'b0);
        send(BNE, 32'hF10, 32'd1, 32'd2, 26'h1, 1'b0, 32'h0, mk(1'b0, 32'h0, 1'b0, 32'h0), 1'b0);
        flush = 1'b1;
        in_valid = 1'b1; in_op = JJ; in_pc = 32'hF20; in_imm = 26'h5;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush2_out_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Flush in the cycle a new request is accepted: both are dropped
        send(BGEZ, 32'hF30, 32'd0, 32'd0, 26'h1, 1'b0, 32'h0, mk(1'b0, 32'h0, 1'b0, 32'h0), 1'b0);
        flush = 1'b1;
        in_valid = 1'b1; in_op = JR; in_rs = 32'h1234;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush1_out_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Latency after flush: result valid exactly 2 cycles after accept
        send(BEQ, 32'hD00, 32'd9, 32'd9, 26'h0, 1'b1, 32'hD04, mk(1'b1, 32'hD04, 1'b0, 32'hD04), 1'b1);
        idle_in();
        @(negedge clk);
        chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain_1", sb.size(), 32'd0);
`ifdef BRU_PERF_CNT_EN
        chk("perf_branches", perf_branches, m_branches);
        chk("perf_mispred", perf_mispred, m_mispred);
`endif

        // Reset with work in flight
        out_ready = 1'b0;
        send(JR, 32'hE00, 32'h5555_0000, 32'h0, 26'h0, 1'b0, 32'h0, mk(1'b0, 32'h0, 1'b0, 32'h0), 1'b0);
        send(BNE, 32'hE10, 32'd1, 32'd2, 26'h7, 1'b0, 32'h0, mk(1'b0, 32'h0, 1'b0, 32'h0), 1'b0);
        idle_in();
        rst = 1'b1;
        m_branches = 0;
        m_mispred = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_taken", {31'd0, out_taken}, 32'd0);
        chk("mid_rst_out_target", out_target, 32'd0);
        chk("mid_rst_redirect_pc", out_redirect_pc, RST_PC_T);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b1;
        send(BGEZ, 32'hE00, 32'd0, 32'd0, 26'h10, 1'b1, 32'hE44, mk(1'b1, 32'hE44, 1'b0, 32'hE44), 1'b1);
        idle_in();
        repeat (6) @(posedge clk);
        #1;
        chk("sb_drain_2", sb.size(), 32'd0);
`ifdef BRU_PERF_CNT_EN
        chk("perf_branches_after_rst", perf_branches, m_branches);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
